// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and constants for the sprite position tracker.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // {up, down, left, right}, active-high once decoded from the pad
    typedef logic [3:0] dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } move_state_t;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int EDGE_TOP    = 3;
    localparam int EDGE_BOTTOM = 2;
    localparam int EDGE_LEFT   = 1;
    localparam int EDGE_RIGHT  = 0;

    localparam int DEF_SCR_W = 640;
    localparam int DEF_SCR_H = 480;

endpackage
`default_nettype wire

// File: rtl/axis_saturate.sv
`default_nettype none
// ============================================================================
// Module      : axis_saturate
// Description : Combinational single-axis step with clamping to [0, MAX].
// Revision    : 1.0 - initial release
// ============================================================================
module axis_saturate #(
    parameter int W    = 10,
    parameter int STEP = 16,
    parameter int MAX  = 624
) (
    input  logic [W-1:0] coord_i,
    input  logic         dec_i,
    input  logic         inc_i,
    output logic [W-1:0] coord_o
);

    localparam logic [W:0] C_STEP = (W+1)'(STEP);
    localparam logic [W:0] C_MAX  = (W+1)'(MAX);

    logic [W:0] w_wide;
    logic [W:0] w_sum;
    logic [W:0] w_diff;

    // One extra bit keeps coord+STEP from wrapping before the clamp compare
    assign w_wide = {1'b0, coord_i};
    assign w_sum  = w_wide + C_STEP;
    assign w_diff = w_wide - C_STEP;

    always_comb begin
        coord_o = coord_i;
        if (dec_i && !inc_i) begin
            coord_o = (w_wide < C_STEP) ? '0 : w_diff[W-1:0];
        end else if (inc_i && !dec_i) begin
            coord_o = (w_sum > C_MAX) ? C_MAX[W-1:0] : w_sum[W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sprite_position_tracker
// Description : Per-frame sprite position update from SNES buttons with
//               diagonal moves, edge saturation and hold auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_position_tracker
    import sprite_pkg::*;
#(
    parameter int W             = 10,
    parameter int SCR_W         = DEF_SCR_W,
    parameter int SCR_H         = DEF_SCR_H,
    parameter int SPR_W         = 16,
    parameter int SPR_H         = 16,
    parameter int STEP          = 16,
    parameter int X0            = 312,
    parameter int Y0            = 232,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Frame_Tick,
    input  logic         Up,
    input  logic         Down,
    input  logic         Left,
    input  logic         Right,
    output logic [W-1:0] Col,
    output logic [W-1:0] Row,
    output logic         Moved,
    output logic [3:0]   Hit_Edge
);

    localparam int MAXC    = SCR_W - SPR_W;
    localparam int MAXR    = SCR_H - SPR_H;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [W-1:0]     C_MAXC      = W'(MAXC);
    localparam logic [W-1:0]     C_MAXR      = W'(MAXR);
    localparam logic [W-1:0]     C_X0        = W'(X0);
    localparam logic [W-1:0]     C_Y0        = W'(Y0);
    localparam logic [CNT_W-1:0] C_DELAY_END = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] C_PER_END   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       C_RST_EDGE  = {Y0 == 0, Y0 == MAXR, X0 == 0, X0 == MAXC};

    generate
        if (SPR_W > SCR_W || SPR_H > SCR_H || STEP < 1 || X0 > MAXC || Y0 > MAXR ||
            X0 < 0 || Y0 < 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
            MAXC >= (1 << W) || MAXR >= (1 << W) || STEP >= (1 << W)) begin : g_bad_params
            $error("sprite_position_tracker: illegal parameter combination");
        end
    endgenerate

    move_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic [W-1:0]     col_q, col_d, row_q, row_d;
    logic             moved_q, moved_d;
    logic [3:0]       edge_q, edge_d;

    dir_t         w_dir;
    dir_t         w_eff;
    logic         w_active;
    logic         w_step;
    logic [W-1:0] w_col_sat;
    logic [W-1:0] w_row_sat;

    // A pressed pair on one axis cancels to no motion on that axis only
    assign w_dir = {~Up, ~Down, ~Left, ~Right};
    assign w_eff[DIR_UP]    = w_dir[DIR_UP]    & ~w_dir[DIR_DOWN];
    assign w_eff[DIR_DOWN]  = w_dir[DIR_DOWN]  & ~w_dir[DIR_UP];
    assign w_eff[DIR_LEFT]  = w_dir[DIR_LEFT]  & ~w_dir[DIR_RIGHT];
    assign w_eff[DIR_RIGHT] = w_dir[DIR_RIGHT] & ~w_dir[DIR_LEFT];
    assign w_active = |w_eff;

    axis_saturate #(.W(W), .STEP(STEP), .MAX(MAXC)) u_col_sat (
        .coord_i (col_q),
        .dec_i   (w_eff[DIR_LEFT]),
        .inc_i   (w_eff[DIR_RIGHT]),
        .coord_o (w_col_sat)
    );

    axis_saturate #(.W(W), .STEP(STEP), .MAX(MAXR)) u_row_sat (
        .coord_i (row_q),
        .dec_i   (w_eff[DIR_UP]),
        .inc_i   (w_eff[DIR_DOWN]),
        .coord_o (w_row_sat)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        w_step  = 1'b0;
        if (Frame_Tick) begin
            unique case (state_q)
                IDLE: begin
                    if (w_active) begin
                        w_step  = 1'b1;
                        dir_d   = w_eff;
                        cnt_d   = '0;
                        state_d = DELAY;
                    end
                end
                DELAY: begin
                    if (!w_active) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (w_eff != dir_q) begin
                        w_step = 1'b1;
                        dir_d  = w_eff;
                        cnt_d  = '0;
                    end else if (cnt_q == C_DELAY_END) begin
                        w_step  = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!w_active) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (w_eff != dir_q) begin
                        w_step  = 1'b1;
                        dir_d   = w_eff;
                        cnt_d   = '0;
                        state_d = DELAY;
                    end else if (cnt_q == C_PER_END) begin
                        w_step = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + C_CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        col_d   = w_step ? w_col_sat : col_q;
        row_d   = w_step ? w_row_sat : row_q;
        moved_d = w_step && ((w_col_sat != col_q) || (w_row_sat != row_q));
        edge_d  = '0;
        edge_d[EDGE_TOP]    = (row_d == '0);
        edge_d[EDGE_BOTTOM] = (row_d == C_MAXR);
        edge_d[EDGE_LEFT]   = (col_d == '0);
        edge_d[EDGE_RIGHT]  = (col_d == C_MAXC);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            col_q   <= C_X0;
            row_q   <= C_Y0;
            moved_q <= 1'b0;
            edge_q  <= C_RST_EDGE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            col_q   <= col_d;
            row_q   <= row_d;
            moved_q <= moved_d;
            edge_q  <= edge_d;
        end
    end

    assign Col      = col_q;
    assign Row      = row_q;
    assign Moved    = moved_q;
    assign Hit_Edge = edge_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_position_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_position_tracker
// Description : Directed scoreboard bench for sprite_position_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_position_tracker;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       moved;
        logic [3:0] hit;
    } exp_t;

    localparam logic [3:0] B_NONE  = 4'b1111;   // {Up,Down,Left,Right}, active-low
    localparam logic [3:0] B_RIGHT = 4'b1110;
    localparam logic [3:0] B_LEFT  = 4'b1101;
    localparam logic [3:0] B_DOWN  = 4'b1011;
    localparam logic [3:0] B_UP    = 4'b0111;
    localparam logic [3:0] B_UDR   = 4'b0010;

    logic       clk;
    logic       Reset;
    logic       Frame_Tick;
    logic       Up, Down, Left, Right;
    logic [9:0] Col, Row;
    logic       Moved;
    logic [3:0] Hit_Edge;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    bit   done;

    sprite_position_tracker dut (
        .Clk        (clk),
        .Reset      (Reset),
        .Frame_Tick (Frame_Tick),
        .Up         (Up),
        .Down       (Down),
        .Left       (Left),
        .Right      (Right),
        .Col        (Col),
        .Row        (Row),
        .Moved      (Moved),
        .Hit_Edge   (Hit_Edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Tick/reset cycles consume one expectation; other cycles must hold it
    initial begin : monitor
        exp_t last;
        exp_t e;
        bit   upd;
        last = '0;
        forever begin
            @(posedge clk);
            upd = Frame_Tick || Reset;
            @(negedge clk);
            if (upd) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow at %0t: got empty queue, expected an entry", $time);
                end else begin
                    e = sb.pop_front();
                    check("col",      Col,             e.col);
                    check("row",      Row,             e.row);
                    check("moved",    {9'd0, Moved},   {9'd0, e.moved});
                    check("hit_edge", {6'd0, Hit_Edge}, {6'd0, e.hit});
                    last = e;
                end
            end else if (!done) begin
                check("hold_col",      Col,             last.col);
                check("hold_row",      Row,             last.row);
                check("hold_moved",    {9'd0, Moved},   10'd0);
                check("hold_hit_edge", {6'd0, Hit_Edge}, {6'd0, last.hit});
            end
        end
    end

    task automatic cyc(input logic rst, input logic tick, input logic [3:0] btn, input exp_t e);
        Reset      = rst;
        Frame_Tick = tick;
        {Up, Down, Left, Right} = btn;
        if (rst || tick) sb.push_back(e);
        @(posedge clk);
        #1;
        Reset      = 1'b0;
        Frame_Tick = 1'b0;
    endtask

    task automatic tick(input logic [3:0] btn, input int col, input int row,
                        input logic moved, input logic [3:0] hit);
        exp_t e;
        e = '{col: 10'(col), row: 10'(row), moved: moved, hit: hit};
        cyc(1'b0, 1'b1, btn, e);
        cyc(1'b0, 1'b0, btn, e);
        cyc(1'b0, 1'b0, btn, e);
    endtask

    task automatic do_reset(input logic tick_too, input logic [3:0] btn);
        exp_t e;
        e = '{col: 10'd312, row: 10'd232, moved: 1'b0, hit: 4'b0000};
        cyc(1'b1, tick_too, btn, e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c;
        int r;
        n_cmp = 0;
        n_bad = 0;
        done  = 1'b0;
        Reset = 1'b1;
        Frame_Tick = 1'b1;
        {Up, Down, Left, Right} = B_RIGHT;

        // Reset wins over ticks and held buttons
        for (int i = 0; i < 4; i++) do_reset(1'b1, B_RIGHT);
        cyc(1'b0, 1'b0, B_NONE, '0);

        // Right hold into REPEAT, then switch to Up at tick 20, release at 29
        for (int t = 1; t <= 29; t++) begin
            c = (t < 9) ? 328 : (t < 13) ? 344 : (t < 17) ? 360 : 376;
            r = (t < 20) ? 232 : (t < 28) ? 216 : 200;
            tick((t <= 19) ? B_RIGHT : (t <= 28) ? B_UP : B_NONE, c, r,
                 (t == 1 || t == 9 || t == 13 || t == 17 || t == 20 || t == 28), 4'b0000);
        end

        // Button activity between ticks must be ignored
        cyc(1'b0, 1'b0, B_LEFT,  '0);
        cyc(1'b0, 1'b0, B_UP,    '0);
        cyc(1'b0, 1'b0, B_UDR,   '0);
        cyc(1'b0, 1'b0, B_DOWN,  '0);
        cyc(1'b0, 1'b0, B_NONE,  '0);

        // Reach REPEAT with Right, then reset while still held
        tick(B_RIGHT, 392, 200, 1'b1, 4'b0000);
        for (int t = 2; t <= 8; t++) tick(B_RIGHT, 392, 200, 1'b0, 4'b0000);
        tick(B_RIGHT, 408, 200, 1'b1, 4'b0000);
        do_reset(1'b0, B_RIGHT);
        cyc(1'b0, 1'b0, B_RIGHT, '0);
        tick(B_RIGHT, 328, 232, 1'b1, 4'b0000);
        tick(B_NONE,  328, 232, 1'b0, 4'b0000);

        // Opposing vertical presses cancel while the horizontal one still moves
        do_reset(1'b0, B_NONE);
        tick(B_UDR,  328, 232, 1'b1, 4'b0000);
        tick(B_NONE, 328, 232, 1'b0, 4'b0000);

        // Walk left to Col=8 with taps, then hold Left against the bound
        do_reset(1'b0, B_NONE);
        for (int k = 0; k < 19; k++) begin
            tick(B_LEFT, 312 - 16 * (k + 1), 232, 1'b1, 4'b0000);
            tick(B_NONE, 312 - 16 * (k + 1), 232, 1'b0, 4'b0000);
        end
        tick(B_LEFT, 0, 232, 1'b1, 4'b0010);
        for (int t = 2; t <= 10; t++) tick(B_LEFT, 0, 232, 1'b0, 4'b0010);
        tick(B_NONE, 0, 232, 1'b0, 4'b0010);

        // Walk down to Row=456, then the bottom clamp at 464
        do_reset(1'b0, B_NONE);
        for (int k = 0; k < 14; k++) begin
            tick(B_DOWN, 312, 232 + 16 * (k + 1), 1'b1, 4'b0000);
            tick(B_NONE, 312, 232 + 16 * (k + 1), 1'b0, 4'b0000);
        end
        tick(B_DOWN, 312, 464, 1'b1, 4'b0100);
        tick(B_NONE, 312, 464, 1'b0, 4'b0100);
        tick(B_DOWN, 312, 464, 1'b0, 4'b0100);
        tick(B_NONE, 312, 464, 1'b0, 4'b0100);

        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
